seq_divider_n: RTL

Parametrised, iterative, unsigned restoring divider. It is the sequential successor to the fixed 8-bit combinational array divider.
- Computes Q = A / B and R = A % B over WIDTH bits.
- Retires UNROLL quotient bits per clock, trading area against latency.
- Uses valid/ready handshakes on both input and output, and flags divide-by-zero.
- Sits between operand-producing datapaths and consumers that tolerate multi-cycle latency.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divider_n.sv | 121 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
// Imported by the divider top and its step logic.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int div_iter(input int width, input int unroll);
    return width / unroll;
  endfunction

  function automatic int div_cnt_w(input int width, input int unroll);
    return $clog2(div_iter(width, unroll) + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift, trial subtract,
// keep or restore, emit one quotient bit.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dsr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;

  assign shl  = {rem, bit_in};
  assign diff = {1'b0, shl} - {2'b00, dsr};

  // A non-negative difference is below dsr, so both top bits are clear.
  assign q_bit   = ~(diff[WIDTH+1] | diff[WIDTH]);
  assign rem_nxt = q_bit ? diff[WIDTH-1:0] : shl[WIDTH-1:0];

endmodule

// File: rtl/seq_divider_n.sv
// Iterative unsigned restoring divider retiring UNROLL quotient bits
// per clock, with valid/ready on both sides and divide-by-zero flag.
module seq_divider_n
  import div_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int ITER = div_iter(WIDTH, UNROLL);
  localparam int CW   = div_cnt_w(WIDTH, UNROLL);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if ((WIDTH < 2) || (WIDTH % UNROLL != 0)) begin : g_bad_cfg
    $fatal(1, "seq_divider_n: UNROLL must divide WIDTH, WIDTH >= 2");
  end

  div_state_e state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic             dbz;
  logic             accept;
  logic             b_zero;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign b_zero      = (b == '0);
  assign q           = dvd;
  assign r           = rem;
  assign div_by_zero = dbz;

  // Quotient bits fill the dividend register from the LSB end.
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    logic [WIDTH-1:0] rem_i;
    logic [WIDTH-1:0] dvd_i;
    logic [WIDTH-1:0] rem_o;
    logic [WIDTH-1:0] dvd_o;
    logic             qb;

    if (i == 0) begin : g_first
      assign rem_i = rem;
      assign dvd_i = dvd;
    end else begin : g_next
      assign rem_i = g_step[i-1].rem_o;
      assign dvd_i = g_step[i-1].dvd_o;
    end

    div_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .rem    (rem_i),
      .dsr    (dsr),
      .bit_in (dvd_i[WIDTH-1]),
      .rem_nxt(rem_o),
      .q_bit  (qb)
    );

    assign dvd_o = {dvd_i[WIDTH-2:0], qb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = b_zero ? DONE : BUSY;
      BUSY: if (cnt == LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd <= '0;
      dsr <= '0;
      rem <= '0;
      dbz <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      if (b_zero) begin
        dvd <= '1;
        rem <= a;
        dbz <= 1'b1;
      end else begin
        dvd <= a;
        dsr <= b;
        rem <= '0;
        dbz <= 1'b0;
        cnt <= '0;
      end
    end else if (state == BUSY) begin
      dvd <= g_step[UNROLL-1].dvd_o;
      rem <= g_step[UNROLL-1].rem_o;
      cnt <= cnt + CW'(1);
    end
  end

endmodule
